// File: rtl/adder_share_arbiter_if.sv
// -----------------------------------------------------------------------------
// adder_share_arbiter_if
//   Bundles the request and response signals of adder_share_arbiter.
//   BITS : adder operand/result width
//   NREQ : number of requesters
//
//   req_valid  [NREQ]       per-requester operation request
//   req_ready  [NREQ]       one-hot grant (accept = req_valid & req_ready)
//   req_a/b    [NREQ*BITS]  operands, requester i at [i*BITS +: BITS]
//   req_cin    [NREQ]       explicit carry-in
//   req_chain  [NREQ]       use stored carry (only while locked)
//   req_lock   [NREQ]       keep the grant after this beat
//   rsp_valid               one-cycle result pulse
//   rsp_id                  requester index of the result
//   rsp_sum/rsp_cout        registered sum and carry-out
//   locked                  high while a requester holds the adder
//
//   master : requester side, slave : arbiter side.
// -----------------------------------------------------------------------------
interface adder_share_arbiter_if #(
  parameter int BITS = 10,
  parameter int NREQ = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*BITS-1:0] req_a;
  logic [NREQ*BITS-1:0] req_b;
  logic [NREQ-1:0]      req_cin;
  logic [NREQ-1:0]      req_chain;
  logic [NREQ-1:0]      req_lock;
  logic                 rsp_valid;
  logic [IDW-1:0]       rsp_id;
  logic [BITS-1:0]      rsp_sum;
  logic                 rsp_cout;
  logic                 locked;

  modport master (
    output req_valid, req_a, req_b, req_cin, req_chain, req_lock,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, locked
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cin, req_chain, req_lock,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, locked
  );
endinterface

// File: rtl/adder_share_arbiter.sv
// -----------------------------------------------------------------------------
// adder_share_arbiter
//   Round-robin arbiter sharing one carry-select adder between NREQ
//   requesters. One add accepted per cycle, result registered one cycle later.
//   A requester may lock the adder for multi-beat adds, chaining the stored
//   carry between beats; an idle lock is force-released after LOCK_TIMEOUT
//   idle cycles (0 disables the timeout).
//
//   clk    : system clock, rising edge
//   reset  : synchronous, active-high reset
//   bus    : adder_share_arbiter_if.slave (request/response signals)
// -----------------------------------------------------------------------------
module adder_share_arbiter #(
  parameter int BITS         = 10,
  parameter int NREQ         = 4,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  adder_share_arbiter_if.slave  bus
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam int LO  = BITS / 2;
  localparam int HI  = BITS - LO;

  localparam logic [0:0] ST_ARB    = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  localparam logic [CW-1:0] IDLE_LAST = CW'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);

  // Carry-select add: lower half ripples, upper half is computed for both
  // carry values and selected by the lower half's carry-out.
  function automatic logic [BITS:0] csel_add(input logic [BITS-1:0] a,
                                             input logic [BITS-1:0] b,
                                             input logic            cin);
    logic [LO:0] lo;
    logic [HI:0] hi0;
    logic [HI:0] hi1;
    lo  = {1'b0, a[LO-1:0]} + {1'b0, b[LO-1:0]} + {{LO{1'b0}}, cin};
    hi0 = {1'b0, a[BITS-1:LO]} + {1'b0, b[BITS-1:LO]};
    hi1 = hi0 + 1'b1;
    return lo[LO] ? {hi1, lo[LO-1:0]} : {hi0, lo[LO-1:0]};
  endfunction

  function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] p);
    return (p == IDW'(NREQ - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [0:0]      state_q,     state_d;
  logic [IDW-1:0]  rr_ptr_q,    rr_ptr_d;
  logic [IDW-1:0]  owner_q,     owner_d;
  logic            carry_q,     carry_d;
  logic [CW-1:0]   idle_cnt_q,  idle_cnt_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]  rsp_id_q,    rsp_id_d;
  logic [BITS-1:0] rsp_sum_q,   rsp_sum_d;
  logic            rsp_cout_q,  rsp_cout_d;

  logic [BITS-1:0] a_arr [NREQ];
  logic [BITS-1:0] b_arr [NREQ];
  logic            arb_found;
  logic [IDW-1:0]  arb_idx;
  logic [IDW-1:0]  cand;
  logic [IDW-1:0]  gnt;
  logic [NREQ-1:0] ready;
  logic            acc;
  logic            cin;
  logic [BITS:0]   sum_full;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = bus.req_a[i*BITS +: BITS];
      b_arr[i] = bus.req_b[i*BITS +: BITS];
    end
  end

  // Circular search for the first valid requester starting at rr_ptr.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDW'((int'(rr_ptr_q) + k) % NREQ);
      if (!arb_found && bus.req_valid[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  // Stage p0: grant, operand select, add.
  always_comb begin
    ready = '0;
    if (state_q == ST_LOCKED) begin
      gnt        = owner_q;
      ready[gnt] = 1'b1;
      cin        = bus.req_chain[gnt] ? carry_q : bus.req_cin[gnt];
    end else begin
      gnt = arb_idx;
      if (arb_found) ready[gnt] = 1'b1;
      cin = bus.req_cin[gnt];
    end
    if (reset) ready = '0;
    acc      = |(ready & bus.req_valid);
    sum_full = csel_add(a_arr[gnt], b_arr[gnt], cin);
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    carry_d     = carry_q;
    idle_cnt_d  = idle_cnt_q;
    rsp_valid_d = acc;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_cout_d  = rsp_cout_q;

    if (acc) begin
      rsp_id_d   = gnt;
      rsp_sum_d  = sum_full[BITS-1:0];
      rsp_cout_d = sum_full[BITS];
      carry_d    = sum_full[BITS];
    end

    if (state_q == ST_ARB) begin
      if (acc) begin
        if (bus.req_lock[gnt]) begin
          state_d    = ST_LOCKED;
          owner_d    = gnt;
          idle_cnt_d = '0;
        end else begin
          rr_ptr_d = next_idx(gnt);
        end
      end
    end else begin
      if (acc) begin
        if (bus.req_lock[owner_q]) begin
          idle_cnt_d = '0;
        end else begin
          state_d  = ST_ARB;
          rr_ptr_d = next_idx(owner_q);
        end
      end else if (LOCK_TIMEOUT != 0 && idle_cnt_q == IDLE_LAST) begin
        state_d  = ST_ARB;
        rr_ptr_d = next_idx(owner_q);
      end else if (LOCK_TIMEOUT != 0) begin
        idle_cnt_d = idle_cnt_q + 1'b1;
      end
    end
  end

  // Stage p1: registered result and arbitration state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_ARB;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      carry_q     <= 1'b0;
      idle_cnt_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      carry_q     <= carry_d;
      idle_cnt_q  <= idle_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_cout_q  <= rsp_cout_d;
    end
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_cout  = rsp_cout_q;
  assign bus.locked    = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_adder_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_adder_share_arbiter
//   Directed scenarios followed by randomized traffic, all checked against a
//   behavioural model of the arbiter kept in this bench.
// -----------------------------------------------------------------------------
module tb_adder_share_arbiter;
  localparam int BITS = 10;
  localparam int NREQ = 4;
  localparam int TO   = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  adder_share_arbiter_if #(.BITS(BITS), .NREQ(NREQ)) bus ();

  adder_share_arbiter #(.BITS(BITS), .NREQ(NREQ), .LOCK_TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Per-requester stimulus, packed onto the interface.
  bit              v_t  [NREQ];
  logic [BITS-1:0] a_t  [NREQ];
  logic [BITS-1:0] b_t  [NREQ];
  bit              c_t  [NREQ];
  bit              ch_t [NREQ];
  bit              lk_t [NREQ];

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i]             = v_t[i];
      bus.req_a[i*BITS +: BITS]    = a_t[i];
      bus.req_b[i*BITS +: BITS]    = b_t[i];
      bus.req_cin[i]               = c_t[i];
      bus.req_chain[i]             = ch_t[i];
      bus.req_lock[i]              = lk_t[i];
    end
  end

  int total = 0;
  int bad   = 0;

  // Reference model state.
  bit m_locked = 0;
  int m_owner = 0, m_rr = 0, m_carry = 0, m_idle = 0;
  int e_valid = 0, e_id = 0, e_sum = 0, e_cout = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input bit v, input int a, input int b,
                         input bit cin, input bit ch, input bit lk);
    v_t[i] = v; a_t[i] = BITS'(a); b_t[i] = BITS'(b);
    c_t[i] = cin; ch_t[i] = ch; lk_t[i] = lk;
  endtask

  task automatic clear_all();
    for (int i = 0; i < NREQ; i++) set_req(i, 0, 0, 0, 0, 0, 0);
  endtask

  // One clock: check grant before the edge, advance model, check outputs after.
  task automatic cycle();
    int g, tot, cin;
    bit acc, lk, rst_now;
    logic [NREQ-1:0] exp_rdy;
    #1;
    exp_rdy = '0; acc = 0; g = 0; rst_now = reset;
    if (!rst_now) begin
      if (m_locked) begin
        g = m_owner;
        exp_rdy = exp_rdy | (NREQ'(1) << g);
      end else begin
        for (int k = 0; k < NREQ; k++) begin
          if (v_t[(m_rr + k) % NREQ]) begin
            g = (m_rr + k) % NREQ;
            exp_rdy = exp_rdy | (NREQ'(1) << g);
            break;
          end
        end
      end
      acc = (exp_rdy != 0) && v_t[g];
    end
    check("ready", 32'(bus.req_ready), 32'(exp_rdy));
    cin = (m_locked && ch_t[g]) ? m_carry : int'(c_t[g]);
    tot = int'(a_t[g]) + int'(b_t[g]) + cin;
    lk  = lk_t[g];
    @(posedge clk);
    #1;
    if (rst_now) begin
      m_locked = 0; m_owner = 0; m_rr = 0; m_carry = 0; m_idle = 0;
      e_valid = 0; e_id = 0; e_sum = 0; e_cout = 0;
    end else if (acc) begin
      e_valid = 1; e_id = g;
      e_sum = tot % (1 << BITS); e_cout = tot >> BITS;
      m_carry = e_cout;
      if (!m_locked) begin
        if (lk) begin m_locked = 1; m_owner = g; m_idle = 0; end
        else m_rr = (g + 1) % NREQ;
      end else if (lk) begin
        m_idle = 0;
      end else begin
        m_locked = 0; m_rr = (g + 1) % NREQ;
      end
    end else begin
      e_valid = 0;
      if (m_locked) begin
        if (TO != 0 && m_idle == TO - 1) begin
          m_locked = 0; m_rr = (m_owner + 1) % NREQ;
        end else begin
          m_idle++;
        end
      end
    end
    check("rsp_valid", 32'(bus.rsp_valid), 32'(e_valid));
    check("rsp_id",    32'(bus.rsp_id),    32'(e_id));
    check("rsp_sum",   32'(bus.rsp_sum),   32'(e_sum));
    check("rsp_cout",  32'(bus.rsp_cout),  32'(e_cout));
    check("locked",    32'(bus.locked),    32'(m_locked));
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    clear_all();
    @(negedge clk);
    do_reset();
    do_reset();
    check("rst_locked", 32'(bus.locked), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);

    // Wrap-around add with carry-out.
    set_req(0, 1, 'h3FF, 'h001, 0, 0, 0);
    #1 check("t1_ready", 32'(bus.req_ready), 32'h1);
    cycle();
    check("t1_sum", 32'(bus.rsp_sum), 32'h000);
    check("t1_cout", 32'(bus.rsp_cout), 32'd1);

    // Chain requested in ARB is ignored.
    set_req(0, 1, 'h001, 'h001, 0, 1, 0);
    cycle();
    check("t5_sum", 32'(bus.rsp_sum), 32'h002);
    clear_all();
    cycle();

    // Round robin with all requesters valid.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 1, i, 3 * i, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      cycle();
      check("t2_id", 32'(bus.rsp_id), 32'(i % NREQ));
      check("t2_valid", 32'(bus.rsp_valid), 32'd1);
    end
    clear_all();

    // Locked two-beat add by requester 2 while requester 1 waits.
    set_req(1, 1, 5, 6, 0, 0, 0);
    cycle();
    set_req(2, 1, 'h3FF, 'h001, 0, 0, 1);
    #1 check("t3_beat1_ready", 32'(bus.req_ready), 32'h4);
    cycle();
    check("t3_beat1_sum", 32'(bus.rsp_sum), 32'h000);
    check("t3_beat1_cout", 32'(bus.rsp_cout), 32'd1);
    set_req(2, 1, 0, 0, 0, 1, 0);
    #1 check("t3_beat2_ready", 32'(bus.req_ready), 32'h4);
    cycle();
    check("t3_beat2_sum", 32'(bus.rsp_sum), 32'h001);
    check("t3_beat2_cout", 32'(bus.rsp_cout), 32'd0);
    set_req(2, 0, 0, 0, 0, 0, 0);
    #1 check("t3_next", 32'(bus.req_ready), 32'h2);
    cycle();
    clear_all();

    // Lock timeout: owner 1 goes idle while requester 0 waits.
    set_req(1, 1, 1, 1, 0, 0, 1);
    cycle();
    set_req(1, 0, 0, 0, 0, 0, 0);
    set_req(0, 1, 7, 8, 1, 0, 0);
    for (int i = 0; i < TO; i++) begin
      #1;
      check("t4_hold_ready", 32'(bus.req_ready), 32'h2);
      check("t4_hold_locked", 32'(bus.locked), 32'd1);
      cycle();
    end
    check("t4_released", 32'(bus.locked), 32'd0);
    #1 check("t4_grant0", 32'(bus.req_ready), 32'h1);
    cycle();
    check("t4_sum", 32'(bus.rsp_sum), 32'h010);
    clear_all();

    // Reset while locked by requester 3.
    set_req(3, 1, 2, 2, 0, 0, 1);
    cycle();
    check("t6_locked", 32'(bus.locked), 32'd1);
    reset = 1'b1;
    #1 check("t6_rst_ready", 32'(bus.req_ready), 32'h0);
    cycle();
    reset = 1'b0;
    check("t6_locked_after", 32'(bus.locked), 32'd0);
    check("t6_valid_after", 32'(bus.rsp_valid), 32'd0);
    set_req(1, 1, 3, 3, 0, 0, 0);
    set_req(3, 1, 4, 4, 0, 0, 0);
    #1 check("t6_rr0", 32'(bus.req_ready), 32'h2);
    cycle();
    clear_all();

    // Randomized traffic with changing load.
    for (int n = 0; n < 3000; n++) begin
      int thr;
      thr = ((n / 64) % 3 == 0) ? 1 : (((n / 64) % 3 == 1) ? 4 : 7);
      for (int i = 0; i < NREQ; i++)
        set_req(i, $urandom_range(0, 7) < thr, int'($urandom), int'($urandom),
                bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                $urandom_range(0, 2) == 0);
      reset = ($urandom_range(0, 199) == 0);
      cycle();
    end
    reset = 1'b0;
    clear_all();
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
